// File: rtl/div_arbiter_if.sv
// ----------------------------------------------------------------------------
// div_arbiter_if
//
// Bundle of all handshake/bus signals around div_arbiter: two requester
// channels, the shared-divider channel, the response channel and busy.
//
//   req0_* / req1_*  : valid/ready + dividend/divisor from each requester
//   div_*            : start pulse + operands to the divider, done + results back
//   rsp_*            : valid/ready + id/quot/rem/dbz to the response consumer
//   busy             : arbiter is not idle
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters, divider datapath, response consumer)
// ----------------------------------------------------------------------------
interface div_arbiter_if #(
    parameter int unsigned WIDTH = 8
);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_dividend;
    logic [WIDTH-1:0] req0_divisor;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_dividend;
    logic [WIDTH-1:0] req1_divisor;

    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_quot;
    logic [WIDTH-1:0] rsp_rem;
    logic             rsp_dbz;

    logic             busy;

    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        output req0_ready,
        input  req1_valid, req1_dividend, req1_divisor,
        output req1_ready,
        output div_start, div_dividend, div_divisor,
        input  div_done, div_quot, div_rem,
        output rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        input  req0_ready,
        output req1_valid, req1_dividend, req1_divisor,
        input  req1_ready,
        input  div_start, div_dividend, div_divisor,
        output div_done, div_quot, div_rem,
        input  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/div_arbiter.sv
// ----------------------------------------------------------------------------
// div_arbiter
//
// Shares one multi-cycle divider between two requesters. Only one division is
// in flight at a time. Ties between requesters are broken round-robin based
// on which requester was served last (req0 wins the first tie after reset).
//
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - synchronous active-low reset
//   arb_io   - div_arbiter_if.slave: requester, divider and response channels
//
// Optional feature (macro DIV_ARB_DBZ_EN):
//   defined   - a zero divisor is answered locally (quot = all ones,
//               rem = dividend, rsp_dbz = 1) without starting the divider
//   undefined - a zero divisor goes to the divider like any other request and
//               rsp_dbz is tied low
// ----------------------------------------------------------------------------
module div_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input logic          i_clk,
    input logic          i_rst_n,
    div_arbiter_if.slave arb_io
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBusy,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;          // requester served most recently
    logic             id_q, id_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIV_ARB_DBZ_EN
    logic             dbz_q, dbz_d;
`endif

    logic             grant_id;
    logic             any_valid;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    // ------------------------------------------------------------------------
    // Grant selection: a lone requester wins outright, a tie goes to the
    // requester that was not served last.
    // ------------------------------------------------------------------------
    always_comb begin
        any_valid = arb_io.req0_valid || arb_io.req1_valid;
        if (arb_io.req0_valid && arb_io.req1_valid) begin
            grant_id = !last_q;
        end else begin
            grant_id = !arb_io.req0_valid;
        end
        sel_dividend = grant_id ? arb_io.req1_dividend : arb_io.req0_dividend;
        sel_divisor  = grant_id ? arb_io.req1_divisor  : arb_io.req0_divisor;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
`ifdef DIV_ARB_DBZ_EN
        dbz_d      = dbz_q;
`endif

        unique case (state_q)
            StIdle: begin
                // Ready is asserted to the granted valid requester, so any
                // valid in idle is a handshake.
                if (any_valid) begin
                    id_d       = grant_id;
                    dividend_d = sel_dividend;
                    divisor_d  = sel_divisor;
`ifdef DIV_ARB_DBZ_EN
                    if (sel_divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = sel_dividend;
                        dbz_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = StIssue;
                    end
`else
                    state_d = StIssue;
`endif
                end
            end

            StIssue: begin
                state_d = StBusy;
            end

            StBusy: begin
                if (arb_io.div_done) begin
                    quot_d  = arb_io.div_quot;
                    rem_d   = arb_io.div_rem;
                    state_d = StResp;
                end
            end

            StResp: begin
                if (arb_io.rsp_ready) begin
                    last_d  = id_q;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs (all derived from registered state except the ready strobes)
    // ------------------------------------------------------------------------
    always_comb begin
        arb_io.req0_ready = 1'b0;
        arb_io.req1_ready = 1'b0;
        if (state_q == StIdle) begin
            arb_io.req0_ready = arb_io.req0_valid && !grant_id;
            arb_io.req1_ready = arb_io.req1_valid && grant_id;
        end

        arb_io.div_start    = (state_q == StIssue);
        arb_io.div_dividend = dividend_q;
        arb_io.div_divisor  = divisor_q;

        arb_io.rsp_valid = (state_q == StResp);
        arb_io.rsp_id    = id_q;
        arb_io.rsp_quot  = quot_q;
        arb_io.rsp_rem   = rem_q;
`ifdef DIV_ARB_DBZ_EN
        arb_io.rsp_dbz   = dbz_q;
`else
        arb_io.rsp_dbz   = 1'b0;
`endif

        arb_io.busy = (state_q != StIdle);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            id_q       <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
`ifdef DIV_ARB_DBZ_EN
            dbz_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
`ifdef DIV_ARB_DBZ_EN
            dbz_q      <= dbz_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int W = 8;
`ifdef DIV_ARB_DBZ_EN
    localparam bit DbzEn = 1'b1;
`else
    localparam bit DbzEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_arbiter_if #(.WIDTH(W)) ifc ();

    div_arbiter #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .arb_io  (ifc)
    );

    // ------------------------------------------------------------------------
    // Divider datapath model: result appears div_lat cycles after start
    // ------------------------------------------------------------------------
    int           div_lat = 4;
    logic         spur_done = 1'b0;
    logic         mdl_done = 1'b0;
    logic [W-1:0] mdl_q = '0;
    logic [W-1:0] mdl_r = '0;
    int           cnt = 0;

    function automatic logic [W-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction

    function automatic logic [W-1:0] ref_rem(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (ifc.div_start) begin
            cnt   <= div_lat;
            mdl_q <= ref_quot(ifc.div_dividend, ifc.div_divisor);
            mdl_r <= ref_rem(ifc.div_dividend, ifc.div_divisor);
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) mdl_done <= 1'b1;
        end
    end

    assign ifc.div_done = mdl_done | spur_done;
    assign ifc.div_quot = spur_done ? 8'hAA : mdl_q;
    assign ifc.div_rem  = spur_done ? 8'h55 : mdl_r;

    // ------------------------------------------------------------------------
    // Checking infrastructure and transaction-level reference model
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } txn_t;

    txn_t exp_q[$];
    int   acc_ids[$];
    int   rsp_ids[$];
    bit   mdl_last = 1'b1;
    bit   mon_en = 1'b0;
    int   n_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sampled at negedge: predicts grants, tracks the outstanding transaction
    // and scores every response handshake.
    task automatic monitor();
        bit   v0, v1, eid;
        txn_t t;
        if (!mon_en) return;
        v0 = ifc.req0_valid;
        v1 = ifc.req1_valid;
        check("busy", ifc.busy, exp_q.size() != 0);
        if (ifc.busy) begin
            check("ready_not_idle", {ifc.req1_ready, ifc.req0_ready}, 2'b00);
        end else if (v0 || v1) begin
            eid = (v0 && v1) ? !mdl_last : !v0;
            check("grant", {ifc.req1_ready, ifc.req0_ready}, eid ? 2'b10 : 2'b01);
            t.id = eid;
            t.a  = eid ? ifc.req1_dividend : ifc.req0_dividend;
            t.b  = eid ? ifc.req1_divisor  : ifc.req0_divisor;
            exp_q.push_back(t);
            acc_ids.push_back(int'(eid));
        end
        if (ifc.div_start) begin
            n_start++;
            if (exp_q.size() > 0) begin
                check("div_dividend", ifc.div_dividend, exp_q[0].a);
                check("div_divisor", ifc.div_divisor, exp_q[0].b);
            end
        end
        if (ifc.rsp_valid && ifc.rsp_ready) begin
            check("rsp_outstanding", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                check("rsp_id", ifc.rsp_id, t.id);
                check("rsp_quot", ifc.rsp_quot, ref_quot(t.a, t.b));
                check("rsp_rem", ifc.rsp_rem, ref_rem(t.a, t.b));
                check("rsp_dbz", ifc.rsp_dbz, DbzEn && (t.b == 0));
                mdl_last = t.id;
                rsp_ids.push_back(int'(t.id));
            end
        end
    endtask

    // One clock: monitor at negedge, return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.req0_valid = 1'b0; ifc.req0_dividend = '0; ifc.req0_divisor = '0;
        ifc.req1_valid = 1'b0; ifc.req1_dividend = '0; ifc.req1_divisor = '0;
        ifc.rsp_ready  = 1'b0;
        spur_done      = 1'b0;
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        acc_ids.delete();
        rsp_ids.delete();
        mdl_last = 1'b1;
        n_start  = 0;
        mon_en   = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, ifc.busy, 0);
        check({tag, "_rsp_valid"}, ifc.rsp_valid, 0);
        check({tag, "_div_start"}, ifc.div_start, 0);
        check({tag, "_rsp_id"}, ifc.rsp_id, 0);
        check({tag, "_rsp_quot"}, ifc.rsp_quot, 0);
        check({tag, "_rsp_rem"}, ifc.rsp_rem, 0);
        check({tag, "_rsp_dbz"}, ifc.rsp_dbz, 0);
        check({tag, "_div_dividend"}, ifc.div_dividend, 0);
        check({tag, "_div_divisor"}, ifc.div_divisor, 0);
    endtask

    // Bounded wait for rsp_valid; expiry counts as a failure.
    task automatic wait_rsp(input string tag, input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            if (ifc.rsp_valid) seen = 1'b1;
            else tick();
        end
        check({tag, "_rsp_seen"}, seen, 1);
    endtask

    // Drop requests, accept responses until nothing is outstanding.
    task automatic drain(input string tag);
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
        ifc.rsp_ready  = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
        tick();
        check({tag, "_drained"}, exp_q.size(), 0);
        ifc.rsp_ready = 1'b0;
    endtask

    typedef struct {
        bit v0;
        bit v1;
        bit r0;
        bit r1;
    } vec_t;

    initial begin
        vec_t tbl[4];
        bit   got;
        int   exp_ids[4];

        tbl[0] = '{v0: 0, v1: 0, r0: 0, r1: 0};
        tbl[1] = '{v0: 1, v1: 0, r0: 1, r1: 0};
        tbl[2] = '{v0: 0, v1: 1, r0: 0, r1: 1};
        tbl[3] = '{v0: 1, v1: 1, r0: 1, r1: 0};  // first tie after reset -> req0
        exp_ids = '{0, 1, 0, 1};

        // Reset state and combinational grant table
        apply_reset();
        check_reset_state("reset");
        for (int i = 0; i < 4; i++) begin
            ifc.req0_valid = tbl[i].v0;
            ifc.req1_valid = tbl[i].v1;
            #1;
            check($sformatf("tbl%0d_r0", i), ifc.req0_ready, tbl[i].r0);
            check($sformatf("tbl%0d_r1", i), ifc.req1_ready, tbl[i].r1);
            ifc.req0_valid = 1'b0;
            ifc.req1_valid = 1'b0;
            tick();
        end

        // Basic transaction 100/7, divider latency 8
        apply_reset();
        div_lat = 8;
        ifc.req0_valid = 1'b1; ifc.req0_dividend = 8'd100; ifc.req0_divisor = 8'd7;
        #1;
        check("basic_ready0", ifc.req0_ready, 1);
        tick();
        ifc.req0_valid = 1'b0;
        check("basic_start", ifc.div_start, 1);
        check("basic_div_a", ifc.div_dividend, 100);
        check("basic_div_b", ifc.div_divisor, 7);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            check("basic_start_once", ifc.div_start, 0);
            if (ifc.div_done) got = 1'b1;
        end
        check("basic_done_seen", got, 1);
        check("basic_no_early_rsp", ifc.rsp_valid, 0);
        tick();
        check("basic_rsp_valid", ifc.rsp_valid, 1);
        check("basic_rsp_id", ifc.rsp_id, 0);
        check("basic_rsp_quot", ifc.rsp_quot, 14);
        check("basic_rsp_rem", ifc.rsp_rem, 2);
        ifc.rsp_ready = 1'b1;
        tick();
        check("basic_rsp_gone", ifc.rsp_valid, 0);
        ifc.rsp_ready = 1'b0;

        // Round-robin with both requesters valid continuously
        apply_reset();
        div_lat = 3;
        ifc.req0_valid = 1'b1; ifc.req0_dividend = 8'd50; ifc.req0_divisor = 8'd5;
        ifc.req1_valid = 1'b1; ifc.req1_dividend = 8'd9;  ifc.req1_divisor = 8'd4;
        ifc.rsp_ready  = 1'b1;
        for (int i = 0; i < 200 && rsp_ids.size() < 4; i++) tick();
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
        check("rr_rsp_count", rsp_ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_ids.size()) check($sformatf("rr_grant%0d", i), acc_ids[i], exp_ids[i]);
            if (i < rsp_ids.size()) check($sformatf("rr_rsp%0d", i), rsp_ids[i], exp_ids[i]);
        end
        drain("rr");

        // Response back-pressure for 5 cycles with another requester waiting
        apply_reset();
        ifc.req1_valid = 1'b1; ifc.req1_dividend = 8'd200; ifc.req1_divisor = 8'd9;
        tick();
        ifc.req1_valid = 1'b0;
        ifc.req0_valid = 1'b1; ifc.req0_dividend = 8'd3; ifc.req0_divisor = 8'd1;
        wait_rsp("bp", 30);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", ifc.rsp_valid, 1);
            check("bp_rsp_id", ifc.rsp_id, 1);
            check("bp_rsp_quot", ifc.rsp_quot, 22);
            check("bp_rsp_rem", ifc.rsp_rem, 2);
            check("bp_ready0", ifc.req0_ready, 0);
            check("bp_start", ifc.div_start, 0);
            tick();
        end
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.req0_valid = 1'b0;
        drain("bp");

        // Reset during BUSY aborts; a late div_done is ignored
        apply_reset();
        div_lat = 8;
        ifc.req1_valid = 1'b1; ifc.req1_dividend = 8'd60; ifc.req1_divisor = 8'd6;
        tick();
        ifc.req1_valid = 1'b0;
        tick(); tick(); tick();
        check("abort_busy", ifc.busy, 1);
        apply_reset();
        check_reset_state("abort");
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("abort_no_rsp", ifc.rsp_valid, 0);
            tick();
        end
        ifc.req1_valid = 1'b1; ifc.req1_dividend = 8'd77; ifc.req1_divisor = 8'd7;
        tick();
        ifc.req1_valid = 1'b0;
        drain("abort");
        check("abort_next_served", rsp_ids.size(), 1);

        // Zero divisor
        apply_reset();
        div_lat = 4;
        ifc.req0_valid = 1'b1; ifc.req0_dividend = 8'd37; ifc.req0_divisor = 8'd0;
        tick();
        ifc.req0_valid = 1'b0;
        wait_rsp("dbz", 30);
        check("dbz_quot", ifc.rsp_quot, 255);
        check("dbz_rem", ifc.rsp_rem, 37);
        check("dbz_flag", ifc.rsp_dbz, DbzEn);
        drain("dbz");
        check("dbz_starts", n_start, DbzEn ? 0 : 1);

        // Spurious div_done in IDLE and ISSUE
        apply_reset();
        div_lat = 4;
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        check("spur_idle_rsp", ifc.rsp_valid, 0);
        check("spur_idle_busy", ifc.busy, 0);
        ifc.req1_valid = 1'b1; ifc.req1_dividend = 8'd90; ifc.req1_divisor = 8'd8;
        tick();
        ifc.req1_valid = 1'b0;
        check("spur_issue_start", ifc.div_start, 1);
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        check("spur_issue_rsp", ifc.rsp_valid, 0);
        check("spur_issue_busy", ifc.busy, 1);
        wait_rsp("spur", 30);
        check("spur_quot", ifc.rsp_quot, 11);
        check("spur_rem", ifc.rsp_rem, 2);
        drain("spur");

        // Randomised traffic against the reference model
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            div_lat = $urandom_range(1, 5);
            ifc.req0_valid    = ($urandom % 3) != 0;
            ifc.req1_valid    = ($urandom % 3) != 0;
            ifc.req0_dividend = W'($urandom);
            ifc.req1_dividend = W'($urandom);
            ifc.req0_divisor  = (($urandom % 8) == 0) ? '0 : W'($urandom);
            ifc.req1_divisor  = (($urandom % 8) == 0) ? '0 : W'($urandom);
            ifc.rsp_ready     = ($urandom % 2) != 0;
            tick();
        end
        drain("rand");
        check("rand_progress", rsp_ids.size() > 50, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width of the shared divider.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 i_clk  in  1  rising-edge clock for all state.
REQ-004 i_rst_n  in  1  synchronous active-low reset.
REQ-005 reqN_valid (N=0,1)  in  1  requester N has an operand pair.
REQ-006 reqN_ready (N=0,1)  out  1  arbiter accepts requester N this cycle.
REQ-007 reqN_dividend, reqN_divisor (N=0,1)  in  WIDTH  operands.
REQ-008 div_start  out  1  one-cycle start pulse to divider datapath.
REQ-009 div_dividend, div_divisor  out  WIDTH  operands to divider, held stable from start until done.
REQ-010 div_done  in  1  divider result valid.
REQ-011 div_quot, div_rem  in  WIDTH  divider results.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  consumer takes response.
REQ-014 rsp_id  out  1  index of the requester the response belongs to.
REQ-015 rsp_quot, rsp_rem  out  WIDTH  response payload.
REQ-016 rsp_dbz  out  1  divide-by-zero flag.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, BUSY, RESP; only one division is outstanding at a time.
REQ-019 IDLE: if any reqN_valid, drive reqN_ready=1 (combinational) for the granted requester only; on valid&&ready latch operands and id -> ISSUE.
REQ-020 Grant: one valid requester is granted directly; if both are valid, the requester not served last is granted (round-robin).
REQ-021 ISSUE: div_start=1 for exactly one cycle -> BUSY; accept-to-div_start latency is 1 cycle.
REQ-022 BUSY: wait for div_done; on div_done latch div_quot/div_rem -> RESP; div_done outside BUSY is ignored.
REQ-023 RESP: rsp_valid=1; rsp_id/quot/rem/dbz held stable until rsp_ready; on handshake update last-served = rsp_id -> IDLE.
REQ-024 Latency: div_done to rsp_valid is 1 cycle; a new request may be accepted in the cycle after the response handshake.
REQ-025 reqN_ready is 0 in all states except IDLE; rsp_ready while rsp_valid=0 has no effect.
REQ-026 Requester dropping valid before its handshake leaves no trace; operands are sampled only at the handshake.

Reset
REQ-027 When i_rst_n=0 at a clock edge: state=IDLE, div_start=0, rsp_valid=0, rsp_id=0, rsp_quot=0, rsp_rem=0, rsp_dbz=0, latched operands=0, last-served=1 (req0 wins the first tie).
REQ-028 Reset mid-operation aborts the transaction with no response; a later div_done is ignored (arbiter is not in BUSY).

Configuration
REQ-029 Macro DIV_ARB_DBZ_EN defined: an accepted request with divisor==0 skips ISSUE/BUSY and goes IDLE->RESP with rsp_quot=all ones, rsp_rem=dividend, rsp_dbz=1, and no div_start.
REQ-030 DIV_ARB_DBZ_EN undefined: a zero divisor is forwarded to the divider like any other request; rsp_dbz is tied to 0.

Verification
REQ-031 Reset, then req0 valid 100/7, div model returns 14/2 after 8 cycles -> div_start one cycle after accept, rsp_valid id=0 quot=14 rem=2 one cycle after div_done.
REQ-032 Both requesters valid continuously (req0 50/5, req1 9/4) -> grant order req0, req1, req0, req1; responses carry ids 0,1,0,1.
REQ-033 rsp_ready held low 5 cycles in RESP -> payload stable, reqN_ready stays 0, no div_start.
REQ-034 Assert i_rst_n=0 during BUSY, then pulse div_done -> no rsp_valid; next req1 request is served normally.
REQ-035 req0 divisor 0, dividend 37: with DIV_ARB_DBZ_EN -> no div_start, rsp quot=255 rem=37 dbz=1; without it -> div_start issued, rsp_dbz=0.
REQ-036 Spurious div_done in IDLE or ISSUE -> ignored; response uses the div_done that occurs in BUSY.
